// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: keeps the fetch PC, reads a 1-cycle synchronous ROM,
// and buffers returned words for decode behind a valid/ready handshake.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [31:0] pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        halted
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic          halted_q;
  logic [CW-1:0] count;
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [31:0]   buf_pc [DEPTH];
  logic [31:0]   buf_ir [DEPTH];

  logic          pop;
  logic [CW:0]   occupancy;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Outputs come only from registered buffer state, never from imem_rdata.
  assign ir_valid  = (count != '0);
  assign ir        = ir_valid ? buf_ir[rptr] : NOP;
  assign pc        = ir_valid ? buf_pc[rptr] : 32'h0;
  assign halted    = halted_q;
  assign imem_addr = fetch_pc;
  assign pop       = ir_valid & ir_ready;

  // Credit check counts the word already in flight so a push never overflows.
  always_comb begin
    occupancy = {1'b0, count} + (CW + 1)'(inflight) - (CW + 1)'(pop);
    imem_en   = !rst && !halted_q && !halt && !redirect_valid
                && (occupancy < (CW + 1)'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      halted_q    <= 1'b0;
      count       <= '0;
      rptr        <= '0;
      wptr        <= '0;
    end else if (halted_q) begin
      inflight <= 1'b0;
    end else if (halt) begin
      halted_q <= 1'b1;
      inflight <= 1'b0;
      count    <= '0;
      rptr     <= '0;
      wptr     <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      inflight <= 1'b0;
      count    <= '0;
      rptr     <= '0;
      wptr     <= '0;
    end else begin
      if (inflight) wptr <= next_ptr(wptr);
      if (pop) rptr <= next_ptr(rptr);
      case ({inflight, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (imem_en) begin
        fetch_pc    <= fetch_pc + 32'd4;
        inflight_pc <= fetch_pc;
      end
      inflight <= imem_en;
    end
  end

  // Storage needs no reset; count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (inflight) begin
      buf_pc[wptr] <= inflight_pc;
      buf_ir[wptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural 1-cycle ROM and hand-computed
// expectations for stream, stall, redirect, wrap, halt and mid-flight reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic [31:0] pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        halted;

  int checks = 0;
  int passes = 0;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .ir(ir), .pc(pc), .ir_valid(ir_valid),
    .ir_ready(ir_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt(halt), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h00b50633;
      32'h0000_0004: return 32'h40b60633;
      32'h0000_0008: return 32'h011626b3;
      32'h0000_0040: return 32'h00c08067;
      default:       return {16'hdead, a[15:0]};
    endcase
  endfunction

  // Synchronous instruction ROM with one cycle of read latency.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= rom_word(imem_addr);
  end

  // Drive one cycle's inputs at the falling edge, then let combinational outputs settle.
  task automatic applyStimulus(input logic r, input logic rdy, input logic rv,
                               input logic [31:0] rpc, input logic h);
    @(negedge clk);
    rst            = r;
    ir_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt           = h;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic checkHead(input string tag, input logic v, input logic [31:0] p,
                           input logic [31:0] w);
    checkOutput({tag, ".valid"}, {31'b0, ir_valid}, {31'b0, v});
    checkOutput({tag, ".pc"}, pc, p);
    checkOutput({tag, ".ir"}, ir, w);
  endtask

  task automatic checkIssue(input string tag, input logic en, input logic [31:0] a);
    checkOutput({tag, ".en"}, {31'b0, imem_en}, {31'b0, en});
    if (en) checkOutput({tag, ".addr"}, imem_addr, a);
  endtask

  initial begin
    rst = 1'b1; ir_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;

    // Reset and straight-line streaming.
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    checkHead("rst", 0, 0, NOP_W);
    checkIssue("rst", 0, 0);
    checkOutput("rst.halted", {31'b0, halted}, 32'h0);
    applyStimulus(0, 1, 0, 0, 0);
    checkIssue("s0", 1, 32'h0);
    checkHead("s0", 0, 0, NOP_W);
    applyStimulus(0, 1, 0, 0, 0);
    checkIssue("s1", 1, 32'h4);
    checkHead("s1", 0, 0, NOP_W);
    applyStimulus(0, 1, 0, 0, 0);
    checkIssue("s2", 1, 32'h8);
    checkHead("s2", 1, 32'h0, 32'h00b50633);
    applyStimulus(0, 1, 0, 0, 0);
    checkHead("s3", 1, 32'h4, 32'h40b60633);
    applyStimulus(0, 1, 0, 0, 0);
    checkHead("s4", 1, 32'h8, 32'h011626b3);

    // Redirect to 0x40 while streaming; the word for 0x10 must never surface.
    applyStimulus(0, 1, 1, 32'h0000_0040, 0);
    checkIssue("rd0", 0, 0);
    checkHead("rd0", 1, 32'hC, 32'hdead000c);
    applyStimulus(0, 1, 0, 0, 0);
    checkIssue("rd1", 1, 32'h40);
    checkHead("rd1", 0, 0, NOP_W);
    applyStimulus(0, 1, 0, 0, 0);
    checkHead("rd2", 0, 0, NOP_W);
    applyStimulus(0, 1, 0, 0, 0);
    checkHead("rd3", 1, 32'h40, 32'h00c08067);

    // Misaligned redirect that also wraps the fetch PC.
    applyStimulus(0, 1, 1, 32'hFFFF_FFFE, 0);
    checkHead("rd4", 1, 32'h44, 32'hdead0044);
    applyStimulus(0, 1, 0, 0, 0);
    checkIssue("wr0", 1, 32'hFFFF_FFFC);
    applyStimulus(0, 1, 0, 0, 0);
    checkIssue("wr1", 1, 32'h0);
    checkHead("wr1", 0, 0, NOP_W);
    applyStimulus(0, 1, 0, 0, 0);
    checkHead("wr2", 1, 32'hFFFF_FFFC, 32'hdeadfffc);

    // Stall with ir_ready low after the first valid word.
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkIssue("st0", 1, 32'h0);
    applyStimulus(0, 0, 0, 0, 0);
    checkIssue("st1", 1, 32'h4);
    applyStimulus(0, 0, 0, 0, 0);
    checkHead("st2", 1, 32'h0, 32'h00b50633);
    checkIssue("st2", 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkHead("st3", 1, 32'h0, 32'h00b50633);
    checkIssue("st3", 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkHead("st4", 1, 32'h0, 32'h00b50633);
    applyStimulus(0, 1, 0, 0, 0);
    checkHead("st5", 1, 32'h0, 32'h00b50633);
    checkIssue("st5", 1, 32'h8);
    applyStimulus(0, 1, 0, 0, 0);
    checkHead("st6", 1, 32'h4, 32'h40b60633);
    checkIssue("st6", 1, 32'hC);
    applyStimulus(0, 1, 0, 0, 0);
    checkHead("st7", 1, 32'h8, 32'h011626b3);

    // Halt wins over a simultaneous redirect and sticks until reset.
    applyStimulus(0, 1, 1, 32'h0000_0080, 1);
    checkIssue("hl0", 0, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1, (i == 5), 32'h0000_0080, 0);
      checkIssue("hl.en", 0, 0);
      checkOutput("hl.valid", {31'b0, ir_valid}, 32'h0);
      checkOutput("hl.halted", {31'b0, halted}, 32'h1);
    end
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("hr.halted", {31'b0, halted}, 32'h0);
    checkIssue("hr0", 1, 32'h0);

    // Reset in the cycle after an issue drops the returning word.
    applyStimulus(1, 1, 0, 0, 0);
    checkIssue("mr0", 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkIssue("mr1", 1, 32'h0);
    checkHead("mr1", 0, 0, NOP_W);
    applyStimulus(0, 1, 0, 0, 0);
    checkHead("mr2", 0, 0, NOP_W);
    applyStimulus(0, 1, 0, 0, 0);
    checkHead("mr3", 1, 32'h0, 32'h00b50633);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
